pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush control for the 5-stage pipeline: load-use interlock, taken-branch
// flush, memory-wait freeze with timeout watchdog, and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  ifid_empty,
    output logic                  idex_we,
    output logic                  idex_empty,
    output logic                  exmem_we,
    output logic                  exmem_empty,
    output logic                  memwb_we,
    output logic                  memwb_empty,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  timeout_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          err_nxt;
    logic          mem_freeze;
    logic          load_use;

    assign mem_freeze = ((state == RUN) && mem_req && !mem_ready) ||
                        ((state == MEM_WAIT) && !mem_ready);

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            tcnt        <= tcnt_nxt;
            timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        err_nxt   = timeout_err;
        unique case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nxt = MEM_WAIT;
                    tcnt_nxt  = TW'(1);
                end
            end
            MEM_WAIT: begin
                // mem_req is ignored here: the frozen EX/MEM register holds the request.
                if (mem_ready) begin
                    state_nxt = RUN;
                    tcnt_nxt  = '0;
                end else if (tcnt == TW'(TIMEOUT)) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = RUN;
                tcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_empty  = 1'b0;
        idex_we     = 1'b1;
        idex_empty  = 1'b0;
        exmem_we    = 1'b1;
        exmem_empty = 1'b0;
        memwb_we    = 1'b1;
        memwb_empty = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_empty  = 1'b1;
            idex_we     = 1'b0;
            idex_empty  = 1'b1;
            exmem_we    = 1'b0;
            exmem_empty = 1'b1;
            memwb_we    = 1'b0;
            memwb_empty = 1'b1;
        end else if (state == ERR) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (mem_freeze) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_empty = 1'b1;
        end else if (branch_taken) begin
            ifid_empty = 1'b1;
            idex_empty = 1'b1;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_empty = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_we && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with a 4-bit
// counter shares the stimulus to exercise stall_cnt saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read, branch_taken, mem_req, mem_ready;

    logic        pc_we, ifid_we, ifid_empty, idex_we, idex_empty;
    logic        exmem_we, exmem_empty, memwb_we, memwb_empty;
    logic [15:0] stall_cnt;
    logic        timeout_err;

    logic        s_pc_we, s_ifid_we, s_ifid_empty, s_idex_we, s_idex_empty;
    logic        s_exmem_we, s_exmem_empty, s_memwb_we, s_memwb_empty;
    logic [3:0]  s_stall_cnt;
    logic        s_timeout_err;

    int checks = 0;
    int errors = 0;

    // {pc_we, ifid_we, ifid_empty, idex_we, idex_empty, exmem_we, exmem_empty, memwb_we, memwb_empty}
    localparam logic [8:0] C_RST    = 9'b0_01_01_01_01;
    localparam logic [8:0] C_NORM   = 9'b1_10_10_10_10;
    localparam logic [8:0] C_LU     = 9'b0_00_11_10_10;
    localparam logic [8:0] C_BR     = 9'b1_11_11_10_10;
    localparam logic [8:0] C_FREEZE = 9'b0_00_00_00_11;
    localparam logic [8:0] C_ERR    = 9'b0_00_00_00_00;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_empty(ifid_empty),
        .idex_we(idex_we), .idex_empty(idex_empty),
        .exmem_we(exmem_we), .exmem_empty(exmem_empty),
        .memwb_we(memwb_we), .memwb_empty(memwb_empty),
        .stall_cnt(stall_cnt), .timeout_err(timeout_err)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT(15), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_empty(s_ifid_empty),
        .idex_we(s_idex_we), .idex_empty(s_idex_empty),
        .exmem_we(s_exmem_we), .exmem_empty(s_exmem_empty),
        .memwb_we(s_memwb_we), .memwb_empty(s_memwb_empty),
        .stall_cnt(s_stall_cnt), .timeout_err(s_timeout_err)
    );

    function automatic logic [8:0] ctl();
        return {pc_we, ifid_we, ifid_empty, idex_we, idex_empty,
                exmem_we, exmem_empty, memwb_we, memwb_empty};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        ex_mem_read = 1'b0; branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #12;
        chk("reset_ctl", 32'(ctl()), 32'(C_RST));
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_ctl", 32'(ctl()), 32'(C_NORM));

        // Load-use on rs2
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd7;
        #1 chk("loaduse_ctl", 32'(ctl()), 32'(C_LU));
        step();
        chk("loaduse_cnt", 32'(stall_cnt), 32'd1);

        // rd = x0 never interlocks
        ex_rd = 5'd0; id_rs2 = 5'd0;
        #1 chk("x0_ctl", 32'(ctl()), 32'(C_NORM));
        step();
        chk("x0_cnt", 32'(stall_cnt), 32'd1);

        // Branch dominates load-use
        branch_taken = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
        #1 chk("br_lu_ctl", 32'(ctl()), 32'(C_BR));
        step();
        chk("br_lu_cnt", 32'(stall_cnt), 32'd1);

        // Memory wait: 3 freeze cycles then release
        idle();
        pulse_rst();
        chk("rst2_cnt", 32'(stall_cnt), 32'd0);
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("freeze%0d_ctl", i), 32'(ctl()), 32'(C_FREEZE));
            step();
        end
        chk("wait_cnt", 32'(stall_cnt), 32'd3);
        mem_ready = 1'b1;
        #1 chk("release_ctl", 32'(ctl()), 32'(C_NORM));
        step();
        chk("release_cnt", 32'(stall_cnt), 32'd3);
        // Back in RUN: a same-cycle completion does not freeze
        #1 chk("samecycle_ctl", 32'(ctl()), 32'(C_NORM));
        mem_req = 1'b0; mem_ready = 1'b0;
        #1 chk("run_idle_ctl", 32'(ctl()), 32'(C_NORM));
        step();
        chk("run_idle_cnt", 32'(stall_cnt), 32'd3);

        // Timeout: request never acknowledged
        mem_req = 1'b1;
        step();
        mem_req = 1'b0;
        for (int i = 2; i <= 15; i++) step();
        chk("pre_to_err", 32'(timeout_err), 32'd0);
        chk("pre_to_ctl", 32'(ctl()), 32'(C_FREEZE));
        step();
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_ctl", 32'(ctl()), 32'(C_ERR));
        chk("to_cnt", 32'(stall_cnt), 32'd19);
        mem_ready = 1'b1; branch_taken = 1'b1;
        #1 chk("err_hold_ctl", 32'(ctl()), 32'(C_ERR));
        step();
        chk("err_hold_err", 32'(timeout_err), 32'd1);
        chk("err_hold_cnt", 32'(stall_cnt), 32'd20);
        #2 rst = 1'b1;
        #1 chk("err_rst_ctl", 32'(ctl()), 32'(C_RST));
        chk("err_rst_err", 32'(timeout_err), 32'd0);
        chk("err_rst_cnt", 32'(stall_cnt), 32'd0);
        idle();
        rst = 1'b0;
        step();
        chk("post_err_ctl", 32'(ctl()), 32'(C_NORM));

        // Asynchronous reset in the middle of MEM_WAIT
        mem_req = 1'b1;
        step();
        step();
        chk("mid_wait_cnt", 32'(stall_cnt), 32'd2);
        #2 rst = 1'b1;
        #1 chk("async_rst_ctl", 32'(ctl()), 32'(C_RST));
        chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
        idle();
        #1 rst = 1'b0;
        step();
        chk("async_post_ctl", 32'(ctl()), 32'(C_NORM));
        chk("async_post_cnt", 32'(stall_cnt), 32'd0);

        // Saturation of the 4-bit counter under a held load-use
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("sat_s14", 32'(s_stall_cnt), 32'd14);
            if (i == 15) chk("sat_s15", 32'(s_stall_cnt), 32'd15);
        end
        chk("sat_s20", 32'(s_stall_cnt), 32'd15);
        chk("sat_wide20", 32'(stall_cnt), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
